frame_align_ctrl: RTL
=====================

Name: frame_align_ctrl

Overview:
- Receive-side sequencer for the CRC check datapath.
- Finds frame alignment in a raw byte stream by matching the FAS pattern, then runs the row/column counters that label every byte for the downstream CRC calculator (demap mode).
- Tracks the sync state through a hunt/presync/sync state machine.
- Counts frames reported as CRC-errored.

Parameters:
- FRAME_COLS, 1041, columns per row: 0-15 overhead, 16-1039 payload, 1040 CRC/spare.
- FRAME_ROWS, 4, rows per frame.
- FAS_PATTERN, 48'hF6F6F6282828, framing bytes at row 0 cols 0-5; MSB byte first.
- MISS_LIMIT, 3, consecutive FAS misses in SYNC that declare loss of frame.
- CNT_WIDTH, 16, width of the CRC error counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data  in  8  raw line byte.
- i_data_valid  in  1  i_data is valid this cycle.
- i_crc_err  in  1  CRC mismatch flag from the CRC calculator.
- i_crc_err_valid  in  1  qualifies i_crc_err; one pulse per frame.
- i_cnt_clr  in  1  synchronous clear of o_crc_err_cnt.
- o_frame_data  out  8  registered copy of i_data.
- o_frame_data_valid  out  1  i_data_valid gated by state != HUNT.
- o_frame_data_fas  out  1  high on row 0, cols 0-5 when aligned.
- o_row_cnt  out  2  row label for o_frame_data.
- o_col_cnt  out  11  column label for o_frame_data.
- o_in_frame  out  1  state == SYNC.
- o_lof  out  1  one-cycle pulse on the SYNC->HUNT transition.
- o_crc_err_cnt  out  CNT_WIDTH  saturating count of errored frames.

Behaviour:
- Reset: the asynchronous active-low reset forces, from any state and mid-frame, the following:
  - state = HUNT.
  - All outputs 0.
  - Shift register = 0; row and col = 0; miss count = 0.
- Shift register:
  - 48-bit history of the last six valid bytes; shifts only when i_data_valid = 1.
  - match = {sr[39:0], i_data} == FAS_PATTERN, evaluated only when i_data_valid = 1.
- Position counters:
  - (row, col) is the position of the current input byte; it advances only on valid bytes.
  - col wraps FRAME_COLS-1 -> 0 and increments row at the wrap.
  - row wraps FRAME_ROWS-1 -> 0.
  - Invalid cycles hold all state.
- State HUNT:
  - Counters are don't-care.
  - On a valid byte with match = 1: go to PRESYNC and load the next position as row 0, col 6. The matched byte is treated as row 0, col 5.
- State PRESYNC:
  - On the valid byte at row 0, col 5: match = 1 -> SYNC; match = 0 -> HUNT.
- State SYNC:
  - On the valid byte at row 0, col 5: match = 1 clears the miss count; match = 0 increments it.
  - When the increment reaches MISS_LIMIT: go to HUNT, pulse o_lof for exactly one cycle, clear the miss count.
- Output stage (one-cycle registered latency, all outputs updated every cycle):
  - o_frame_data <= i_data.
  - o_frame_data_valid <= i_data_valid && state != HUNT. State here is the value before the transition, so the first matched byte in HUNT is not forwarded.
  - o_row_cnt and o_col_cnt carry the current position when state != HUNT, else 0.
  - o_frame_data_fas <= valid && state != HUNT && row == 0 && col <= 5.
- o_in_frame is registered from the state and asserts one cycle after the SYNC entry edge.
- Error counter, evaluated each cycle:
  - i_cnt_clr with no increment -> 0.
  - i_cnt_clr together with i_crc_err_valid && i_crc_err -> 1. The clear takes priority, then the new event is counted.
  - Otherwise it increments on i_crc_err_valid && i_crc_err and saturates at all-ones.
  - Errors are counted only while state == SYNC; events are ignored in HUNT and PRESYNC.
- Widths: col compare is 11-bit unsigned; FRAME_COLS <= 2048 and FRAME_ROWS <= 4 are required.

Test Plan:
- Clean aligned frames, continuous valid, starting mid-frame (reset released at an arbitrary byte):
  - PRESYNC after the first FAS; o_in_frame = 1 one cycle after the second FAS col 5.
  - Row 3, col 1040 carries o_row_cnt = 3, o_col_cnt = 1040.
  - o_frame_data_fas is high for exactly 6 bytes per frame.
- Random i_data_valid gaps at about 30%: counters hold on gaps; labels identical to the gap-free run; no spurious states.
- In SYNC, corrupt FAS byte 3 in 2 consecutive frames, then a good frame: o_in_frame stays 1, no o_lof. Then 3 consecutive bad frames: o_lof pulses once and state returns to HUNT.
- False FAS in the payload while in HUNT, with no FAS one frame later: PRESYNC then HUNT; o_in_frame never asserts.
- i_crc_err_valid = 1 with i_crc_err = 1 for 5 frames, then 1 frame with i_crc_err = 0: o_crc_err_cnt = 5.
  - i_cnt_clr asserted on the same cycle as an error -> 1.
  - Force the count to 16'hFFFF plus one more error -> it stays 16'hFFFF.
- Assert i_rst_n = 0 mid-row in SYNC, asynchronously between clock edges: all outputs drop to 0 immediately. Re-acquisition takes two FAS frames.

Source files
------------

// File: rtl/frame_align_ctrl.sv
// Receive-side frame aligner: hunts for the FAS pattern, then labels each byte with row/column
// for the downstream CRC calculator and tracks sync state and CRC-errored frames.
module frame_align_ctrl #(
   parameter int unsigned FRAME_COLS  = 1041,
   parameter int unsigned FRAME_ROWS  = 4,
   parameter logic [47:0] FAS_PATTERN = 48'hF6F6F6282828,
   parameter int unsigned MISS_LIMIT  = 3,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [7:0]           i_data,
   input  logic                 i_data_valid,
   input  logic                 i_crc_err,
   input  logic                 i_crc_err_valid,
   input  logic                 i_cnt_clr,
   output logic [7:0]           o_frame_data,
   output logic                 o_frame_data_valid,
   output logic                 o_frame_data_fas,
   output logic [1:0]           o_row_cnt,
   output logic [10:0]          o_col_cnt,
   output logic                 o_in_frame,
   output logic                 o_lof,
   output logic [CNT_WIDTH-1:0] o_crc_err_cnt
);

   localparam int unsigned    MissW     = $clog2(MISS_LIMIT + 1);
   localparam logic [MissW-1:0] MissLimit = MissW'(MISS_LIMIT);
   localparam logic [10:0]    ColLast   = 11'(FRAME_COLS - 1);
   localparam logic [1:0]     RowLast   = 2'(FRAME_ROWS - 1);

   typedef enum logic [1:0] {StHunt, StPresync, StSync} state_e;

   state_e           state_q;
   logic [47:0]      sr_q;
   logic [1:0]       row_q;
   logic [10:0]      col_q;
   logic [MissW-1:0] miss_q;

   logic             match;
   logic             fas_slot;
   logic             aligned;
   logic             crc_inc;
   logic [MissW-1:0] miss_inc;
   logic [1:0]       row_nxt;
   logic [10:0]      col_nxt;

   assign match    = i_data_valid && ({sr_q[39:0], i_data} == FAS_PATTERN);
   assign fas_slot = (row_q == 2'd0) && (col_q == 11'd5);
   assign aligned  = (state_q != StHunt);
   assign crc_inc  = (state_q == StSync) && i_crc_err_valid && i_crc_err;
   assign miss_inc = miss_q + MissW'(1);

   always_comb begin
      row_nxt = row_q;
      col_nxt = col_q + 11'd1;
      if (col_q == ColLast) begin
         col_nxt = 11'd0;
         row_nxt = (row_q == RowLast) ? 2'd0 : row_q + 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q            <= StHunt;
         sr_q               <= '0;
         row_q              <= '0;
         col_q              <= '0;
         miss_q             <= '0;
         o_frame_data       <= '0;
         o_frame_data_valid <= 1'b0;
         o_frame_data_fas   <= 1'b0;
         o_row_cnt          <= '0;
         o_col_cnt          <= '0;
         o_in_frame         <= 1'b0;
         o_lof              <= 1'b0;
         o_crc_err_cnt      <= '0;
      end else begin
         // Output labels describe the byte just accepted, using the pre-transition state.
         o_frame_data       <= i_data;
         o_frame_data_valid <= i_data_valid && aligned;
         o_row_cnt          <= aligned ? row_q : 2'd0;
         o_col_cnt          <= aligned ? col_q : 11'd0;
         o_frame_data_fas   <= i_data_valid && aligned && (row_q == 2'd0) && (col_q <= 11'd5);
         o_in_frame         <= (state_q == StSync);
         o_lof              <= 1'b0;

         if (i_data_valid) begin
            sr_q  <= {sr_q[39:0], i_data};
            row_q <= row_nxt;
            col_q <= col_nxt;
            case (state_q)
               StHunt: begin
                  if (match) begin
                     // The matched byte is row 0 col 5, so the next one is col 6.
                     state_q <= StPresync;
                     row_q   <= 2'd0;
                     col_q   <= 11'd6;
                  end
               end
               StPresync: begin
                  if (fas_slot) state_q <= match ? StSync : StHunt;
               end
               StSync: begin
                  if (fas_slot) begin
                     if (match) begin
                        miss_q <= '0;
                     end else if (miss_inc == MissLimit) begin
                        state_q <= StHunt;
                        o_lof   <= 1'b1;
                        miss_q  <= '0;
                     end else begin
                        miss_q <= miss_inc;
                     end
                  end
               end
               default: state_q <= StHunt;
            endcase
         end

         // Clear wins over a simultaneous event, which is then counted from zero.
         if (i_cnt_clr) begin
            o_crc_err_cnt <= crc_inc ? CNT_WIDTH'(1) : '0;
         end else if (crc_inc && (o_crc_err_cnt != '1)) begin
            o_crc_err_cnt <= o_crc_err_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule
